us_beam_sweep_scheduler: RTL
============================

# us_beam_sweep_scheduler

Sequencer for the 3-channel ultrasonic phased-array transmitter. Holds a sweep configuration accepted over a valid/ready port and steps the transmitter's `delay_value` through a list of steering positions. Each position gets a settle window, a realigned transmit burst of whole 40 kHz periods and a receive/listen window. Sits between the UART command decoder and the dual-signal generator, and gates and resynchronises that generator.

## Interface
Parameters:
- `PERIOD_CYCLES`, 10000: clk cycles per 40 kHz period (400 MHz clk).
- `SETTLE_CYCLES`, 4: cycles `delay_value` is held before a burst; must be ≥2, the generator's internal register depth.
- `DELAY_W`, 16: width of delay fields.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  config word valid.
- `cfg_ready`  out  1  config accept; equals (state==IDLE).
- `cfg_start`  in  DELAY_W  delay of first position.
- `cfg_step`  in  DELAY_W  delay increment per position (unsigned, modular).
- `cfg_count`  in  8  number of positions; 0 is treated as 1.
- `cfg_burst`  in  8  periods per burst; 0 is treated as 1.
- `cfg_listen`  in  24  listen cycles per position; 0 means no listen window.
- `start`  in  1  sweep start request, sampled in IDLE only.
- `abort`  in  1  terminate sweep; sampled in all states.
- `delay_value`  out  DELAY_W  to generator.
- `gen_sync`  out  1  1-cycle pulse on first burst cycle; drives generator reset to phase-align its counter.
- `tx_enable`  out  1  gates generator outputs.
- `listen`  out  1  receive window.
- `busy`  out  1  state != IDLE.
- `done`  out  1  1-cycle pulse at sweep completion.
- `step_idx`  out  8  current position index.

## Operation
- States: IDLE, SETTLE, BURST, LISTEN, DONE.
- Config registers reset to start=0, step=0, count=1, burst=1, listen=0. `cfg_valid && cfg_ready` captures all cfg fields.
- In IDLE, `start` starts a sweep: `step_idx`←0, `delay_value`←start, and the state goes to SETTLE. If `cfg_valid` and `start` coincide, the new config is captured and used, including the new start delay.
- SETTLE lasts SETTLE_CYCLES cycles, then the state goes to BURST.
- BURST lasts burst×PERIOD_CYCLES cycles. `tx_enable`=1 throughout and `gen_sync`=1 on its first cycle only. Then the state goes to LISTEN, or directly to the next-step decision if listen=0.
- LISTEN lasts `cfg_listen` cycles with `listen`=1.
- Next-step decision: if step_idx+1 < count, then step_idx++, `delay_value`←wrap(delay_value+step), and the state goes to SETTLE. Otherwise the state goes to DONE.
- wrap(x): the sum is computed in DELAY_W+1 bits. If the sum ≥ 2×PERIOD_CYCLES, subtract 2×PERIOD_CYCLES once. Config values ≥ 2×PERIOD_CYCLES are reduced the same way on capture.
- DONE lasts 1 cycle with `done`=1, then the state goes to IDLE. `delay_value` keeps its last value.
- `abort` has priority over everything, including `start`. Any state goes to IDLE on the next edge with `tx_enable`, `listen`, `gen_sync` and `busy` = 0. No `done` pulse is produced, and `step_idx`/`delay_value` hold.
- `cfg_valid` outside IDLE is ignored; `cfg_ready`=0 there.

## Timing
- All outputs are registered, except `cfg_ready` and `busy`, which decode the state register.
- Reset values: `delay_value`=0, `gen_sync`=0, `tx_enable`=0, `listen`=0, `done`=0, `step_idx`=0, state IDLE (so `busy`=0, `cfg_ready`=1).
- Start sampled at edge E0: SETTLE is active from E0 and the first `tx_enable` appears at E0+SETTLE_CYCLES.
- Per-position duration is SETTLE_CYCLES + burst×PERIOD_CYCLES + listen cycles. The `done` pulse occupies the cycle after the last listen (or burst) cycle of the final position.
- `delay_value` changes only on entry to SETTLE, never during BURST or LISTEN.
- Reset mid-sweep drops all outputs asynchronously and restores the config registers to their reset values.

## Structure
- Shared package `us_ctrl_pkg`: state enum, `PERIOD_CYCLES`/`DELAY_MAX` (2×PERIOD_CYCLES−1) constants, and the wrap function.
- One sub-module, `us_burst_timer`: a loadable cycle counter plus period counter. It produces end-of-settle, end-of-burst and end-of-listen strobes. The top level holds the FSM and the config/delay registers.

## Test plan
All scenarios use PERIOD_CYCLES=20 and SETTLE_CYCLES=4.
- Reset held, then released → all outputs at reset values, `cfg_ready`=1, `busy`=0.
- cfg start=2, step=5, count=3, burst=2, listen=10, then `start` → `delay_value` 2/7/12, each with 40-cycle `tx_enable`, a `gen_sync` pulse, and 10-cycle `listen`; `done` exactly 162 cycles after the start edge.
- start=35, step=10, count=2 → delays 35, then 5 (45−40).
- `abort` on cycle 10 of BURST at step_idx 1 → `tx_enable` 0 and `busy` 0 at the next edge; `done` never pulses; `step_idx`=1 and `cfg_ready`=1.
- count=0, burst=0, listen=0 → one position with a 20-cycle burst, no `listen`; `done` at start+24.
- `cfg_valid` with start=9 during BURST is ignored; `cfg_valid`+`start` in the same IDLE cycle with start=9 → first `delay_value`=9.

Source files
------------

// File: rtl/us_beam_sweep_scheduler_pkg.sv
// Shared definitions for the ultrasonic beam sweep controller: state codes,
// nominal timing constants and the modular delay wrap helper.
package us_ctrl_pkg;

  localparam int unsigned PERIOD_CYCLES_DEFAULT = 10000;
  localparam int unsigned DELAY_MAX             = 2 * PERIOD_CYCLES_DEFAULT - 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_BURST  = 3'd2;
  localparam logic [2:0] ST_LISTEN = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // A delay may exceed the two-period span by less than one span, so a single
  // conditional subtraction is enough to bring it back into range.
  function automatic logic [31:0] wrap_delay(input logic [31:0] sum,
                                             input logic [31:0] span);
    return (sum >= span) ? (sum - span) : sum;
  endfunction

endpackage

// File: rtl/us_beam_sweep_scheduler_if.sv
// Sweep configuration valid/ready port between the command decoder (master)
// and the sweep scheduler (slave).
interface us_beam_sweep_scheduler_if #(
  parameter int unsigned DELAY_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DELAY_W-1:0] cfg_start;
  logic [DELAY_W-1:0] cfg_step;
  logic [7:0]         cfg_count;
  logic [7:0]         cfg_burst;
  logic [23:0]        cfg_listen;

  modport master (
    output cfg_valid, cfg_start, cfg_step, cfg_count, cfg_burst, cfg_listen,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_step, cfg_count, cfg_burst, cfg_listen,
    output cfg_ready
  );
endinterface

// File: rtl/us_beam_sweep_scheduler_burst_timer.sv
// Loadable window timer: settle countdown, burst of whole generator periods,
// and listen countdown, each signalled by an end strobe on its last cycle.
module us_burst_timer
  import us_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load_settle,
  input  logic        load_burst,
  input  logic        load_listen,
  input  logic [7:0]  burst_periods,
  input  logic [23:0] listen_cycles,
  output logic        settle_end,
  output logic        burst_end,
  output logic        listen_end
);

  localparam int unsigned CW = 24;

  localparam logic [1:0] M_NONE   = 2'd0;
  localparam logic [1:0] M_SETTLE = 2'd1;
  localparam logic [1:0] M_BURST  = 2'd2;
  localparam logic [1:0] M_LISTEN = 2'd3;

  logic [1:0]    mode;
  logic [CW-1:0] cyc;
  logic [7:0]    per;
  logic          cyc_zero;
  logic          per_zero;

  assign cyc_zero = (cyc == '0);
  assign per_zero = (per == '0);

  // cyc counts down inside the current window (or period); per counts the
  // remaining whole periods of a burst. Loads always win over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode <= M_NONE;
      cyc  <= '0;
      per  <= '0;
    end else if (clear) begin
      mode <= M_NONE;
      cyc  <= '0;
      per  <= '0;
    end else if (load_settle) begin
      mode <= M_SETTLE;
      cyc  <= CW'(SETTLE_CYCLES - 1);
    end else if (load_burst) begin
      mode <= M_BURST;
      cyc  <= CW'(PERIOD_CYCLES - 1);
      per  <= burst_periods - 8'd1;
    end else if (load_listen) begin
      mode <= M_LISTEN;
      cyc  <= listen_cycles - 24'd1;
    end else if (mode != M_NONE) begin
      if (!cyc_zero) begin
        cyc <= cyc - CW'(1);
      end else if (mode == M_BURST && !per_zero) begin
        per <= per - 8'd1;
        cyc <= CW'(PERIOD_CYCLES - 1);
      end else begin
        mode <= M_NONE;
      end
    end
  end

  assign settle_end = (mode == M_SETTLE) && cyc_zero;
  assign burst_end  = (mode == M_BURST)  && cyc_zero && per_zero;
  assign listen_end = (mode == M_LISTEN) && cyc_zero;

endmodule

// File: rtl/us_beam_sweep_scheduler.sv
// Beam sweep sequencer: steps the generator delay through a list of steering
// positions, each with settle, phase-aligned burst and listen windows.
module us_beam_sweep_scheduler
  import us_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DELAY_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  us_beam_sweep_scheduler_if.slave  cfg,
  input  logic                      start,
  input  logic                      abort,
  output logic [DELAY_W-1:0]        delay_value,
  output logic                      gen_sync,
  output logic                      tx_enable,
  output logic                      listen,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                step_idx
);

  localparam logic [31:0] SPAN = 32'(2 * PERIOD_CYCLES);

  logic [2:0]         state;
  logic [DELAY_W-1:0] start_r;
  logic [DELAY_W-1:0] step_r;
  logic [7:0]         count_r;
  logic [7:0]         burst_r;
  logic [23:0]        listen_r;

  logic               cfg_fire;
  logic               launch;
  logic               settle_go;
  logic               burst_go;
  logic               listen_go;
  logic               step_fin;
  logic               last_pos;
  logic [8:0]         next_idx;
  logic [DELAY_W:0]   delay_sum;
  logic [DELAY_W-1:0] delay_adv;
  logic [DELAY_W-1:0] cfg_start_red;
  logic [DELAY_W-1:0] cfg_step_red;
  logic               settle_end;
  logic               burst_end;
  logic               listen_end;
  logic               load_settle;
  logic               load_burst;
  logic               load_listen;

  assign cfg.cfg_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);

  always_comb begin
    cfg_fire      = cfg.cfg_valid && (state == ST_IDLE);
    launch        = (state == ST_IDLE) && start;
    settle_go     = (state == ST_SETTLE) && settle_end;
    burst_go      = (state == ST_BURST) && burst_end;
    listen_go     = (state == ST_LISTEN) && listen_end;
    step_fin      = (burst_go && (listen_r == '0)) || listen_go;
    next_idx      = {1'b0, step_idx} + 9'd1;
    last_pos      = (next_idx >= {1'b0, count_r});
    delay_sum     = {1'b0, delay_value} + {1'b0, step_r};
    delay_adv     = DELAY_W'(wrap_delay(32'(delay_sum), SPAN));
    cfg_start_red = DELAY_W'(wrap_delay(32'(cfg.cfg_start), SPAN));
    cfg_step_red  = DELAY_W'(wrap_delay(32'(cfg.cfg_step), SPAN));
    load_settle   = !abort && (launch || (step_fin && !last_pos));
    load_burst    = !abort && settle_go;
    load_listen   = !abort && burst_go && (listen_r != '0);
  end

  // Config capture is part of the IDLE handshake and is independent of the
  // sweep FSM, so it completes even in a cycle where abort is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_r  <= '0;
      step_r   <= '0;
      count_r  <= 8'd1;
      burst_r  <= 8'd1;
      listen_r <= '0;
    end else if (cfg_fire) begin
      start_r  <= cfg_start_red;
      step_r   <= cfg_step_red;
      count_r  <= (cfg.cfg_count == '0) ? 8'd1 : cfg.cfg_count;
      burst_r  <= (cfg.cfg_burst == '0) ? 8'd1 : cfg.cfg_burst;
      listen_r <= cfg.cfg_listen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      delay_value <= '0;
      step_idx    <= '0;
      gen_sync    <= 1'b0;
      tx_enable   <= 1'b0;
      listen      <= 1'b0;
      done        <= 1'b0;
    end else begin
      gen_sync <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        tx_enable <= 1'b0;
        listen    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state       <= ST_SETTLE;
              step_idx    <= '0;
              delay_value <= cfg_fire ? cfg_start_red : start_r;
            end
          end
          ST_SETTLE: begin
            if (settle_end) begin
              state     <= ST_BURST;
              tx_enable <= 1'b1;
              gen_sync  <= 1'b1;
            end
          end
          ST_BURST: begin
            if (burst_end) begin
              tx_enable <= 1'b0;
              if (listen_r != '0) begin
                state  <= ST_LISTEN;
                listen <= 1'b1;
              end
            end
          end
          ST_LISTEN: begin
            if (listen_end) listen <= 1'b0;
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
        // End of a position (burst with no listen, or listen): next or done.
        if (step_fin) begin
          if (!last_pos) begin
            state       <= ST_SETTLE;
            step_idx    <= next_idx[7:0];
            delay_value <= delay_adv;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

  us_burst_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .clear         (abort),
    .load_settle   (load_settle),
    .load_burst    (load_burst),
    .load_listen   (load_listen),
    .burst_periods (burst_r),
    .listen_cycles (listen_r),
    .settle_end    (settle_end),
    .burst_end     (burst_end),
    .listen_end    (listen_end)
  );

endmodule
